// File: rtl/goomba_pkg.sv
// -----------------------------------------------------------------------------
// goomba_pkg
// Shared types and constants for the goomba movement scheduler:
//   - tile_t        : background tile codes returned by the tile ROM/RAM
//   - dir_t         : walking direction of a goomba
//   - sched_state_t : scheduler FSM states
//   - playfield geometry (12 rows x 17 columns) and the parking x of a
//     stomped goomba
// No ports (package).
// -----------------------------------------------------------------------------
package goomba_pkg;

  typedef enum logic [7:0] {
    TILE_BDR = 8'd0,
    TILE_SKY = 8'd1,
    TILE_BLK = 8'd2,
    TILE_GND = 8'd3
  } tile_t;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } dir_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EVAL    = 3'd1,
    REQ_TOP = 3'd2,
    REQ_BOT = 3'd3,
    WAIT    = 3'd4,
    UPDATE  = 3'd5
  } sched_state_t;

  localparam int NUM_ROWS = 12;
  localparam int NUM_COLS = 17;
  localparam int ROW_W    = 4;
  localparam int COL_W    = 5;

  // A stomped goomba is parked off-screen at this x.
  localparam int DEAD_X   = 1000;

endpackage

// File: rtl/goomba_tile_index.sv
// -----------------------------------------------------------------------------
// goomba_tile_index
// Combinational tile addressing for one goomba. Given the sprite's top-left
// corner and walking direction it returns the tile rows covering the sprite's
// top and bottom edges and the column just ahead of its leading edge, each
// saturated into the playfield (negative values clamp to 0).
//
// Parameters:
//   CHARACTER_WIDTH : sprite edge in pixels
//   BLOCK_WIDTH     : tile edge in pixels
// Ports:
//   x, y     in  signed 32 : sprite top-left corner in pixels
//   dir      in  dir_t     : walking direction
//   top_row  out 4         : row holding the sprite's top edge (0..11)
//   bot_row  out 4         : row holding the sprite's bottom edge (0..11)
//   lead_col out 5         : column one pixel beyond the leading edge (0..16)
// -----------------------------------------------------------------------------
module goomba_tile_index
  import goomba_pkg::*;
#(
  parameter int CHARACTER_WIDTH = 42,
  parameter int BLOCK_WIDTH     = 40
) (
  input  logic signed [31:0] x,
  input  logic signed [31:0] y,
  input  dir_t               dir,
  output logic [ROW_W-1:0]   top_row,
  output logic [ROW_W-1:0]   bot_row,
  output logic [COL_W-1:0]   lead_col
);

  // Saturate a signed tile index into 0..hi.
  function automatic logic [7:0] sat_index(input logic signed [31:0] v, input int hi);
    if (v < 0) begin
      return 8'd0;
    end else if (v > hi) begin
      return 8'(hi);
    end else begin
      return v[7:0];
    end
  endfunction

  logic signed [31:0] lead_px;
  logic signed [31:0] col_raw;
  logic signed [31:0] top_raw;
  logic signed [31:0] bot_raw;

  // Probe the pixel just outside the sprite on the side it is walking toward.
  assign lead_px  = (dir == LEFT) ? (x - 32'sd1) : (x + 32'sd1 + CHARACTER_WIDTH);

  // Signed division truncates toward zero, so -1/40 gives 0; anything still
  // negative is caught by the saturation.
  assign col_raw  = lead_px / BLOCK_WIDTH;
  assign top_raw  = y / BLOCK_WIDTH;
  assign bot_raw  = (y + CHARACTER_WIDTH - 32'sd1) / BLOCK_WIDTH;

  assign lead_col = COL_W'(sat_index(col_raw, NUM_COLS - 1));
  assign top_row  = ROW_W'(sat_index(top_raw, NUM_ROWS - 1));
  assign bot_row  = ROW_W'(sat_index(bot_raw, NUM_ROWS - 1));

endmodule

// File: rtl/goomba_scheduler.sv
// -----------------------------------------------------------------------------
// goomba_scheduler
// On each movement tick, sweeps all goomba slots in order. For each live slot
// it checks Mario contact (stomp from above kills the goomba, side contact
// sets the sticky lose flag and ends the sweep), then reads the two tiles in
// front of the goomba through a single shared lookup port, and finally steps
// the goomba one pixel, turning around at blocks and screen edges.
//
// Optional feature (macro GOOMBA_SCHED_RESPAWN_EN):
//   Defined   : every slot gets an 8-bit respawn counter; a stomped goomba
//               comes back at its start x after RESPAWN_TICKS accepted ticks.
//   Undefined : stomps are permanent until reset; no counters exist.
//
// Ports:
//   movement_clock in  1        : clock
//   reset          in  1        : asynchronous, active-high
//   tick           in  1        : one-cycle movement request
//   mario_x/y      in  int      : Mario top-left corner
//   goomba_y       in  int      : shared goomba top y
//   tile_req       out 1        : tile lookup strobe
//   tile_row       out 4        : lookup row (registered)
//   tile_col       out 5        : lookup column (registered)
//   tile_data      in  8        : tile code, valid one cycle after tile_req
//   goomba_x       out int[N]   : per-slot x position
//   alive          out N        : per-slot alive mask
//   lose           out 1        : sticky Mario side-contact flag
//   busy           out 1        : sweep in progress
//   done           out 1        : one-cycle pulse when a sweep ends
//   overrun        out 1        : sticky; a tick arrived during a sweep
// -----------------------------------------------------------------------------
module goomba_scheduler
  import goomba_pkg::*;
#(
  parameter int NUM_GOOMBAS     = 4,
  parameter int CHARACTER_WIDTH = 42,
  parameter int BLOCK_WIDTH     = 40,
  parameter int SCREEN_WIDTH    = 640,
  parameter int STARTX_BASE     = 200,
  parameter int STARTX_STEP     = 100
`ifdef GOOMBA_SCHED_RESPAWN_EN
  ,
  parameter int RESPAWN_TICKS   = 255
`endif
) (
  input  logic                   movement_clock,
  input  logic                   reset,
  input  logic                   tick,
  input  logic signed [31:0]     mario_x,
  input  logic signed [31:0]     mario_y,
  input  logic signed [31:0]     goomba_y,
  output logic                   tile_req,
  output logic [ROW_W-1:0]       tile_row,
  output logic [COL_W-1:0]       tile_col,
  input  logic [7:0]             tile_data,
  output logic signed [31:0]     goomba_x [NUM_GOOMBAS],
  output logic [NUM_GOOMBAS-1:0] alive,
  output logic                   lose,
  output logic                   busy,
  output logic                   done,
  output logic                   overrun
);

  localparam int SLOT_W = (NUM_GOOMBAS > 1) ? $clog2(NUM_GOOMBAS) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_GOOMBAS - 1);

  sched_state_t      state;
  sched_state_t      state_n;
  logic [SLOT_W-1:0] slot;
  dir_t              dir [NUM_GOOMBAS];

  logic [7:0]        tile_top_q;
  logic [7:0]        tile_bot_q;

  // FSM decisions consumed by the register block
  logic              accept;
  logic              adv;
  logic              kill;
  logic              set_lose;
  logic              walk;
  logic              revive;
  logic              done_n;

  // Current slot view and contact tests
  logic signed [31:0] cur_x;
  dir_t               cur_dir;
  logic               h_overlap;
  logic               v_overlap;
  logic               stomp;
  logic               side_hit;

  // Walking step
  logic               blocked;
  dir_t               new_dir;
  logic signed [31:0] new_x;

  logic [ROW_W-1:0]   idx_top_row;
  logic [ROW_W-1:0]   idx_bot_row;
  logic [COL_W-1:0]   idx_lead_col;

`ifdef GOOMBA_SCHED_RESPAWN_EN
  logic [7:0]         resp_cnt [NUM_GOOMBAS];
`endif

  assign cur_x   = goomba_x[slot];
  assign cur_dir = dir[slot];

  goomba_tile_index #(
    .CHARACTER_WIDTH (CHARACTER_WIDTH),
    .BLOCK_WIDTH     (BLOCK_WIDTH)
  ) u_tile_index (
    .x        (cur_x),
    .y        (goomba_y),
    .dir      (cur_dir),
    .top_row  (idx_top_row),
    .bot_row  (idx_bot_row),
    .lead_col (idx_lead_col)
  );

  // A stomp is Mario's feet exactly on the goomba's head while horizontally
  // overlapping; any other box overlap counts as side contact.
  assign h_overlap = (mario_x + CHARACTER_WIDTH >= cur_x) &&
                     (mario_x <= cur_x + CHARACTER_WIDTH);
  assign v_overlap = (mario_y + CHARACTER_WIDTH >= goomba_y) &&
                     (mario_y <= goomba_y + CHARACTER_WIDTH);
  assign stomp     = h_overlap && (mario_y + CHARACTER_WIDTH == goomba_y);
  assign side_hit  = h_overlap && v_overlap;

  assign blocked = (tile_top_q == TILE_BLK) || (tile_bot_q == TILE_BLK) ||
                   ((cur_dir == LEFT)  && (cur_x <= 0)) ||
                   ((cur_dir == RIGHT) && (cur_x + CHARACTER_WIDTH >= SCREEN_WIDTH));
  assign new_dir = blocked ? ((cur_dir == LEFT) ? RIGHT : LEFT) : cur_dir;
  assign new_x   = (new_dir == RIGHT) ? (cur_x + 32'sd1) : (cur_x - 32'sd1);

  assign busy     = (state != IDLE);
  assign tile_req = (state == REQ_TOP) || (state == REQ_BOT);

  always_comb begin
    state_n  = state;
    accept   = 1'b0;
    adv      = 1'b0;
    kill     = 1'b0;
    set_lose = 1'b0;
    walk     = 1'b0;
    revive   = 1'b0;
    case (state)
      IDLE: begin
        if (tick && !lose) begin
          accept  = 1'b1;
          state_n = EVAL;
        end
      end
      EVAL: begin
        if (!alive[slot]) begin
`ifdef GOOMBA_SCHED_RESPAWN_EN
          // Restore in place and re-evaluate the same slot next cycle so the
          // revived goomba walks on this sweep.
          if (resp_cnt[slot] == 8'd0) begin
            revive = 1'b1;
          end else begin
            adv = 1'b1;
          end
`else
          adv = 1'b1;
`endif
        end else if (stomp) begin
          kill = 1'b1;
          adv  = 1'b1;
        end else if (side_hit) begin
          set_lose = 1'b1;
          state_n  = IDLE;
        end else begin
          state_n = REQ_TOP;
        end
      end
      REQ_TOP: state_n = REQ_BOT;
      REQ_BOT: state_n = WAIT;
      WAIT:    state_n = UPDATE;
      UPDATE: begin
        walk = 1'b1;
        adv  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    if (adv) begin
      state_n = (slot == LAST_SLOT) ? IDLE : EVAL;
    end
  end

  assign done_n = (state != IDLE) && (state_n == IDLE);

  // Control and per-slot state
  always_ff @(posedge movement_clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      slot     <= '0;
      lose     <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
      tile_row <= '0;
      tile_col <= '0;
      alive    <= '1;
      for (int i = 0; i < NUM_GOOMBAS; i++) begin
        goomba_x[i] <= 32'(STARTX_BASE + i * STARTX_STEP);
        dir[i]      <= RIGHT;
      end
    end else begin
      state <= state_n;
      done  <= done_n;

      // A tick that cannot be taken is dropped; the sweep carries on.
      if (tick && (state != IDLE)) begin
        overrun <= 1'b1;
      end

      if (accept) begin
        slot <= '0;
      end else if (adv && (slot != LAST_SLOT)) begin
        slot <= slot + 1'b1;
      end

      if (set_lose) begin
        lose <= 1'b1;
      end

      // Address the top tile on entry to REQ_TOP, the bottom one on entry
      // to REQ_BOT; the leading column is shared by both lookups.
      if ((state == EVAL) && (state_n == REQ_TOP)) begin
        tile_row <= idx_top_row;
        tile_col <= idx_lead_col;
      end else if (state == REQ_TOP) begin
        tile_row <= idx_bot_row;
      end

      if (kill) begin
        alive[slot]    <= 1'b0;
        goomba_x[slot] <= 32'(DEAD_X);
      end else if (walk) begin
        goomba_x[slot] <= new_x;
        dir[slot]      <= new_dir;
      end else if (revive) begin
        alive[slot]    <= 1'b1;
        goomba_x[slot] <= 32'(STARTX_BASE) + 32'(STARTX_STEP) * 32'(slot);
        dir[slot]      <= RIGHT;
      end
    end
  end

  // Tile results: top arrives during REQ_BOT, bottom during WAIT
  always_ff @(posedge movement_clock) begin
    if (state == REQ_BOT) begin
      tile_top_q <= tile_data;
    end
    if (state == WAIT) begin
      tile_bot_q <= tile_data;
    end
  end

`ifdef GOOMBA_SCHED_RESPAWN_EN
  always_ff @(posedge movement_clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_GOOMBAS; i++) begin
        resp_cnt[i] <= 8'd0;
      end
    end else if (kill) begin
      resp_cnt[slot] <= 8'(RESPAWN_TICKS);
    end else if (accept) begin
      for (int i = 0; i < NUM_GOOMBAS; i++) begin
        if (!alive[i] && (resp_cnt[i] != 8'd0)) begin
          resp_cnt[i] <= resp_cnt[i] - 8'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_goomba_scheduler.sv
// -----------------------------------------------------------------------------
// tb_goomba_scheduler
// Table of per-tick stimulus records with hand-derived expected positions,
// alive mask, lose flag and sweep length, pushed to a scoreboard queue when
// the tick is driven and compared when the sweep ends. Hand-written sequences
// cover reset values, overrun, reset during a sweep and the right screen edge.
// -----------------------------------------------------------------------------
module tb_goomba_scheduler;
  import goomba_pkg::*;

  localparam int N = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               tick;
  logic signed [31:0] mario_x, mario_y, goomba_y;
  logic               tile_req;
  logic [3:0]         tile_row;
  logic [4:0]         tile_col;
  logic [7:0]         tile_data = 8'd1;
  logic signed [31:0] goomba_x [N];
  logic [N-1:0]       alive;
  logic               lose, busy, done, overrun;

  int total = 0;
  int bad   = 0;

  logic [7:0] tiles [12][17];

  always #5 clk = ~clk;

  // Tile memory model: one-cycle read latency
  always @(posedge clk) begin
    if (tile_req) tile_data <= tiles[tile_row][tile_col];
  end

  goomba_scheduler dut (
    .movement_clock (clk),
    .reset          (rst),
    .tick           (tick),
    .mario_x        (mario_x),
    .mario_y        (mario_y),
    .goomba_y       (goomba_y),
    .tile_req       (tile_req),
    .tile_row       (tile_row),
    .tile_col       (tile_col),
    .tile_data      (tile_data),
    .goomba_x       (goomba_x),
    .alive          (alive),
    .lose           (lose),
    .busy           (busy),
    .done           (done),
    .overrun        (overrun)
  );

  typedef struct {
    int         mx;
    int         my;
    int         brow;
    int         bcol;
    bit         sweep;
    int         cycles;
    int         x0;
    int         x1;
    int         x2;
    int         x3;
    logic [3:0] ealive;
    bit         elose;
  } vec_t;

  vec_t vt [7];
  vec_t sb [$];

  function automatic vec_t mk(int mx, int my, int br, int bc, bit sw, int cyc,
                              int x0, int x1, int x2, int x3, logic [3:0] al, bit lo);
    vec_t v;
    v.mx = mx; v.my = my; v.brow = br; v.bcol = bc; v.sweep = sw; v.cycles = cyc;
    v.x0 = x0; v.x1 = x1; v.x2 = x2; v.x3 = x3; v.ealive = al; v.elose = lo;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_tiles();
    for (int r = 0; r < 12; r++)
      for (int c = 0; c < 17; c++)
        tiles[r][c] = 8'(TILE_SKY);
  endtask

  task automatic check_reset(input string tag);
    for (int i = 0; i < N; i++)
      check($sformatf("%s_x%0d", tag, i), goomba_x[i], 200 + 100 * i);
    check({tag, "_alive"}, int'(alive), 15);
    check({tag, "_lose"}, int'(lose), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_overrun"}, int'(overrun), 0);
    check({tag, "_tile_req"}, int'(tile_req), 0);
    check({tag, "_tile_row"}, int'(tile_row), 0);
    check({tag, "_tile_col"}, int'(tile_col), 0);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  // Drive one tick and count cycles until done (bounded). Cycle 1 is the
  // first cycle after the accepting edge.
  task automatic do_sweep(output int cyc, output int busy_low);
    busy_low = 0;
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    cyc = 1;
    while (!done && cyc < 200) begin
      if (!busy) busy_low++;
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc, bl, seen;
    vec_t e;

    rst = 1'b1; tick = 1'b0;
    mario_x = 0; mario_y = 0; goomba_y = 360;
    clear_tiles();

    //                mx   my   brow bcol sw cyc  x0   x1   x2    x3   alive    lose
    vt[0] = mk(  0,   0,  -1, -1, 1, 21, 201, 301, 401,  501, 4'b1111, 0);
    vt[1] = mk(  0,   0,   9,  8, 1, 21, 202, 300, 402,  502, 4'b1111, 0);
    vt[2] = mk(  0,   0,  10,  7, 1, 21, 203, 301, 403,  503, 4'b1111, 0);
    vt[3] = mk(403, 318,  -1, -1, 1, 17, 204, 302, 1000, 504, 4'b1011, 0);
    vt[4] = mk(  0,   0,  -1, -1, 1, 17, 205, 303, 1000, 505, 4'b1011, 0);
    vt[5] = mk(463, 360,  -1, -1, 1, 13, 206, 304, 1000, 505, 4'b1011, 1);
    vt[6] = mk(  0,   0,  -1, -1, 0,  0, 206, 304, 1000, 505, 4'b1011, 1);

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset("rst0");

    for (int v = 0; v < 7; v++) begin
      clear_tiles();
      if (vt[v].brow >= 0) tiles[vt[v].brow][vt[v].bcol] = 8'(TILE_BLK);
      mario_x = vt[v].mx;
      mario_y = vt[v].my;
      sb.push_back(vt[v]);
      cyc = 0; seen = 0; bl = 0;
      if (vt[v].sweep) begin
        do_sweep(cyc, bl);
        check($sformatf("v%0d_busy_during", v), bl, 0);
        check($sformatf("v%0d_busy_at_done", v), int'(busy), 0);
      end else begin
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        repeat (30) begin
          if (busy || done) seen++;
          @(negedge clk);
        end
      end
      e = sb.pop_front();
      if (e.sweep) check($sformatf("v%0d_cycles", v), cyc, e.cycles);
      else         check($sformatf("v%0d_ignored_tick_activity", v), seen, 0);
      check($sformatf("v%0d_x0", v), goomba_x[0], e.x0);
      check($sformatf("v%0d_x1", v), goomba_x[1], e.x1);
      check($sformatf("v%0d_x2", v), goomba_x[2], e.x2);
      check($sformatf("v%0d_x3", v), goomba_x[3], e.x3);
      check($sformatf("v%0d_alive", v), int'(alive), int'(e.ealive));
      check($sformatf("v%0d_lose", v), int'(lose), int'(e.elose));
    end

    // Overrun: a second tick three cycles into a sweep is dropped
    clear_tiles();
    mario_x = 0; mario_y = 0;
    do_reset();
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;          // cycle 1
    @(negedge clk);                       // cycle 2
    @(negedge clk); tick = 1'b1;          // cycle 3
    @(negedge clk); tick = 1'b0;          // cycle 4
    check("ovr_flag", int'(overrun), 1);
    cyc = 4;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("ovr_cycles", cyc, 21);
    for (int i = 0; i < N; i++)
      check($sformatf("ovr_x%0d", i), goomba_x[i], 201 + 100 * i);
    @(negedge clk);
    check("ovr_no_second_sweep", int'(busy), 0);

    // Reset during a sweep, together with a tick: reset wins
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1; tick = 1'b1;
    @(posedge clk); #1;
    check_reset("midrst");
    @(negedge clk); rst = 1'b0; tick = 1'b0;
    @(negedge clk);
    check("midrst_idle_after", int'(busy), 0);

    // Right screen edge: slot 3 reaches 598 after 98 ticks, turns on the 99th
    for (int k = 0; k < 98; k++) do_sweep(cyc, bl);
    check("wall98_x0", goomba_x[0], 298);
    check("wall98_x3", goomba_x[3], 598);
    do_sweep(cyc, bl);
    check("wall99_cycles", cyc, 21);
    check("wall99_x0", goomba_x[0], 299);
    check("wall99_x2", goomba_x[2], 499);
    check("wall99_x3", goomba_x[3], 597);
    do_sweep(cyc, bl);
    check("wall100_x3", goomba_x[3], 596);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
